// File: rtl/uart_cmd_scheduler.sv
// rtl/uart_cmd_scheduler.sv - UART motion-command frame scheduler; STOP watchdog built only with SCHED_WATCHDOG_EN
module uart_cmd_scheduler #(
    parameter int unsigned CLK_FREQ_HZ          = 50_000_000,
    parameter int unsigned GAP_CYCLES           = CLK_FREQ_HZ / 1000,
    parameter int unsigned REPEAT_CYCLES        = CLK_FREQ_HZ / 2,
    parameter int unsigned TIMEOUT_CYCLES       = CLK_FREQ_HZ * 2,
    parameter int unsigned FRAME_TIMEOUT_CYCLES = CLK_FREQ_HZ / 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_code,
    input  logic        frame_done,
    output logic        frame_start,
    output logic [2:0]  frame_cmd,
    output logic        busy,
    output logic [2:0]  cur_cmd,
    output logic [15:0] frames_sent,
    output logic        err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_GAP} state_t;

    localparam logic [31:0] GAP_W = 32'(GAP_CYCLES);
    localparam logic [31:0] REP_W = 32'(REPEAT_CYCLES);
    localparam logic [31:0] FTO_W = 32'(FRAME_TIMEOUT_CYCLES);

    state_t      state_q;
    logic        frame_start_q, busy_q, err_q;
    logic [2:0]  frame_cmd_q, cur_cmd_q;
    logic [15:0] frames_q;
    logic [31:0] rep_q, ftimer_q, gap_q;
    logic        pend_flag_q, pend_flag_d;
    logic [2:0]  pend_q, pend_d;
    logic [2:0]  code_norm;
    logic        take_cmd;
    logic        wd_fire;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Unknown codes fold to STOP; a repeat of the active command is dropped unless something is queued.
    assign code_norm = (cmd_code > 3'd4) ? 3'd0 : cmd_code;
    assign take_cmd  = cmd_valid && !((code_norm == cur_cmd_q) && !pend_flag_q);

`ifdef SCHED_WATCHDOG_EN
    localparam logic [31:0] TO_W = 32'(TIMEOUT_CYCLES);
    logic [31:0] wd_q;

    assign wd_fire = !cmd_valid && (wd_q >= TO_W) && (cur_cmd_q != 3'd0) && !pend_flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (cmd_valid || wd_fire) begin
            wd_q <= '0;
        end else if (wd_q < TO_W) begin
            wd_q <= wd_q + 32'd1;
        end
    end
`else
    assign wd_fire = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin : g_no_watchdog
    end
`endif

    // A fresh command in the cycle IDLE consumes the slot must survive the consume.
    always_comb begin
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        if (state_q == S_IDLE && pend_flag_q) pend_flag_d = 1'b0;
        if (wd_fire) begin
            pend_d      = 3'd0;
            pend_flag_d = 1'b1;
        end
        if (take_cmd) begin
            pend_d      = code_norm;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_cmd_q   <= 3'd0;
            cur_cmd_q     <= 3'd0;
            frames_q      <= 16'd0;
            rep_q         <= '0;
            ftimer_q      <= '0;
            gap_q         <= '0;
            pend_q        <= 3'd0;
            pend_flag_q   <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            pend_flag_q   <= pend_flag_d;
            frame_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rep_q <= sat_inc(rep_q);
                    if (pend_flag_q) begin
                        state_q       <= S_ISSUE;
                        frame_cmd_q   <= pend_q;
                        frame_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end else if (REP_W != 32'd0 && rep_q == REP_W) begin
                        state_q       <= S_ISSUE;
                        frame_cmd_q   <= cur_cmd_q;
                        frame_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    cur_cmd_q <= frame_cmd_q;
                    ftimer_q  <= '0;
                    state_q   <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (frame_done) begin
                        frames_q <= frames_q + 16'd1;
                        gap_q    <= '0;
                        state_q  <= S_GAP;
                    end else if (sat_inc(ftimer_q) >= FTO_W) begin
                        err_q   <= 1'b1;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        ftimer_q <= sat_inc(ftimer_q);
                    end
                end
                S_GAP: begin
                    if (gap_q >= GAP_W) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        rep_q   <= '0;
                    end else begin
                        gap_q <= sat_inc(gap_q);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign frame_start = frame_start_q;
    assign frame_cmd   = frame_cmd_q;
    assign busy        = busy_q;
    assign cur_cmd     = cur_cmd_q;
    assign frames_sent = frames_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// tb/tb_uart_cmd_scheduler.sv - directed self-checking bench for uart_cmd_scheduler
module tb_uart_cmd_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, frame_done = 1'b0;
    logic [2:0]  cmd_code = 3'd0;
    logic        frame_start, busy, err_timeout;
    logic [2:0]  frame_cmd, cur_cmd;
    logic [15:0] frames_sent;

    logic        cmd_valid_r = 1'b0, frame_done_r = 1'b0;
    logic [2:0]  cmd_code_r = 3'd0;
    logic        frame_start_r, busy_r, err_timeout_r;
    logic [2:0]  frame_cmd_r, cur_cmd_r;
    logic [15:0] frames_sent_r;

    int tests = 0;
    int fails = 0;

    uart_cmd_scheduler #(
        .CLK_FREQ_HZ(50_000_000), .GAP_CYCLES(4), .REPEAT_CYCLES(0),
        .TIMEOUT_CYCLES(100), .FRAME_TIMEOUT_CYCLES(50)
    ) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .frame_done(frame_done), .frame_start(frame_start), .frame_cmd(frame_cmd),
        .busy(busy), .cur_cmd(cur_cmd), .frames_sent(frames_sent), .err_timeout(err_timeout)
    );

    uart_cmd_scheduler #(
        .CLK_FREQ_HZ(50_000_000), .GAP_CYCLES(4), .REPEAT_CYCLES(20),
        .TIMEOUT_CYCLES(100), .FRAME_TIMEOUT_CYCLES(50)
    ) u_rep (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_r), .cmd_code(cmd_code_r),
        .frame_done(frame_done_r), .frame_start(frame_start_r), .frame_cmd(frame_cmd_r),
        .busy(busy_r), .cur_cmd(cur_cmd_r), .frames_sent(frames_sent_r), .err_timeout(err_timeout_r)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; frame_done = 1'b0; cmd_valid_r = 1'b0; frame_done_r = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] c);
        cmd_code = c; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (frame_cmd !== 3'd0) begin fails++; $display("FAIL reset_frame_cmd: got %0d expected 0", frame_cmd); end
        tests++; if (cur_cmd !== 3'd0) begin fails++; $display("FAIL reset_cur_cmd: got %0d expected 0", cur_cmd); end
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL reset_frames_sent: got %0d expected 0", frames_sent); end
        tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL reset_err_timeout: got %b expected 0", err_timeout); end
        rst = 1'b0;
    endtask

    task automatic test_single_command();
        do_reset();
        send(3'd1);
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL single_early_start: got %b expected 0", frame_start); end
        step();
        tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL single_start: got %b expected 1", frame_start); end
        tests++; if (frame_cmd !== 3'd1) begin fails++; $display("FAIL single_frame_cmd: got %0d expected 1", frame_cmd); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
        step();
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL single_start_width: got %b expected 0", frame_start); end
        tests++; if (cur_cmd !== 3'd1) begin fails++; $display("FAIL single_cur_cmd: got %0d expected 1", cur_cmd); end
        step();
        pulse_done();
        tests++; if (frames_sent !== 16'd1) begin fails++; $display("FAIL single_frames_sent: got %0d expected 1", frames_sent); end
        repeat (4) step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_gap_busy: got %b expected 1", busy); end
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_after_gap: got %b expected 0", busy); end
    endtask

    task automatic test_overwrite_and_duplicate();
        int cnt, idx;
        logic [2:0] got;
        do_reset();
        send(3'd1); step(); step();
        send(3'd2); send(3'd3);
        pulse_done();
        cnt = 0; idx = -1; got = 3'd7;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (frame_start) begin cnt++; if (idx < 0) begin idx = k; got = frame_cmd; end end
        end
        tests++; if (cnt !== 1) begin fails++; $display("FAIL overwrite_count: got %0d expected 1", cnt); end
        tests++; if (got !== 3'd3) begin fails++; $display("FAIL overwrite_cmd: got %0d expected 3", got); end
        tests++; if (idx !== 6) begin fails++; $display("FAIL overwrite_gap_spacing: got %0d expected 6", idx); end

        pulse_done();
        for (int k = 0; k < 20 && busy; k++) step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL dup_idle: got %b expected 0", busy); end
        send(3'd3);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin step(); if (frame_start) cnt++; end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL dup_dropped: got %0d starts expected 0", cnt); end

        send(3'd1); step(); step();
        cmd_code = 3'd4; cmd_valid = 1'b1; frame_done = 1'b1;
        step();
        cmd_valid = 1'b0; frame_done = 1'b0;
        tests++; if (frames_sent !== 16'd3) begin fails++; $display("FAIL simul_frames_sent: got %0d expected 3", frames_sent); end
        cnt = 0; idx = -1; got = 3'd7;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (frame_start) begin cnt++; if (idx < 0) begin idx = k; got = frame_cmd; end end
        end
        tests++; if (got !== 3'd4) begin fails++; $display("FAIL simul_cmd: got %0d expected 4", got); end
        tests++; if (idx !== 6) begin fails++; $display("FAIL simul_after_gap: got %0d expected 6", idx); end

        pulse_done();
        for (int k = 0; k < 20 && busy; k++) step();
        send(3'd7);
        step();
        tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL norm_start: got %b expected 1", frame_start); end
        tests++; if (frame_cmd !== 3'd0) begin fails++; $display("FAIL norm_cmd: got %0d expected 0", frame_cmd); end
    endtask

    task automatic test_frame_timeout();
        do_reset();
        send(3'd2); step(); step();
        repeat (49) step();
        tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b expected 0", err_timeout); end
        step();
        tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL timeout_set: got %b expected 1", err_timeout); end
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL timeout_frames: got %0d expected 0", frames_sent); end
        repeat (4) step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL timeout_gap_busy: got %b expected 1", busy); end
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_idle: got %b expected 0", busy); end
        pulse_done();
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL stray_done_ignored: got %0d expected 0", frames_sent); end
        tests++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout); end
    endtask

    task automatic test_repeat();
        int idx;
        logic [2:0] got;
        logic b5;
        do_reset();
        cmd_code_r = 3'd1; cmd_valid_r = 1'b1;
        step();
        cmd_valid_r = 1'b0;
        step(); step(); step();
        frame_done_r = 1'b1;
        step();
        frame_done_r = 1'b0;
        idx = -1; got = 3'd7; b5 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 5) b5 = busy_r;
            if (frame_start_r && idx < 0) begin idx = k; got = frame_cmd_r; end
        end
        tests++; if (b5 !== 1'b0) begin fails++; $display("FAIL repeat_idle_entry: got %b expected 0", b5); end
        tests++; if (idx !== 26) begin fails++; $display("FAIL repeat_timing: got %0d expected 26", idx); end
        tests++; if (got !== 3'd1) begin fails++; $display("FAIL repeat_cmd: got %0d expected 1", got); end
    endtask

    task automatic test_reset_mid_frame();
        int cnt;
        do_reset();
        send(3'd5);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin step(); if (frame_start) cnt++; end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL code5_as_stop_dropped: got %0d starts expected 0", cnt); end
        send(3'd3); step(); step();
        pulse_done();
        for (int k = 0; k < 20 && busy; k++) step();
        send(3'd2); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        tests++; if (frame_cmd !== 3'd0) begin fails++; $display("FAIL midrst_frame_cmd: got %0d expected 0", frame_cmd); end
        tests++; if (cur_cmd !== 3'd0) begin fails++; $display("FAIL midrst_cur_cmd: got %0d expected 0", cur_cmd); end
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL midrst_frames: got %0d expected 0", frames_sent); end
        pulse_done();
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL late_done_ignored: got %0d expected 0", frames_sent); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL late_done_busy: got %b expected 0", busy); end
    endtask

    task automatic test_watchdog();
        int n, idx, cnt;
        logic [2:0] got;
        do_reset();
        send(3'd1); step(); step();
        pulse_done();
        n = 3; idx = -1; got = 3'd7;
        while (n < 150) begin
            step(); n++;
            if (frame_start && idx < 0) begin idx = n; got = frame_cmd; end
        end
`ifdef SCHED_WATCHDOG_EN
        tests++; if (idx !== 102) begin fails++; $display("FAIL wd_stop_timing: got %0d expected 102", idx); end
        tests++; if (got !== 3'd0) begin fails++; $display("FAIL wd_stop_cmd: got %0d expected 0", got); end
        pulse_done();
        cnt = 0;
        for (int k = 0; k < 200; k++) begin step(); if (frame_start) cnt++; end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL wd_no_reinject: got %0d starts expected 0", cnt); end
        tests++; if (cur_cmd !== 3'd0) begin fails++; $display("FAIL wd_cur_stop: got %0d expected 0", cur_cmd); end
`else
        cnt = (idx < 0) ? 0 : 1;
        tests++; if (cnt !== 0) begin fails++; $display("FAIL no_wd_no_frame: got %0d starts expected 0 (cmd %0d)", cnt, got); end
        tests++; if (cur_cmd !== 3'd1) begin fails++; $display("FAIL no_wd_cur_cmd: got %0d expected 1", cur_cmd); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_command();
        test_overwrite_and_duplicate();
        test_frame_timeout();
        test_repeat();
        test_reset_mid_frame();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
